// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU.
// A requester is granted in IDLE. Its operands, function field and ALUop are latched.
// The latched values drive the ALU for one EXEC cycle, and the result is registered at the end of that cycle.
// DONE then pulses the winner's done line.
// Round-robin arbitration uses a single last-grant bit.
module alu_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    input  logic [5:0]  func0,
    input  logic [5:0]  func1,
    input  logic [1:0]  op0,
    input  logic [1:0]  op1,
    output logic [31:0] alu_A,
    output logic [31:0] alu_B,
    output logic [5:0]  alu_func,
    output logic [1:0]  alu_op,
    input  logic [31:0] alu_out,
    input  logic        alu_zero,
    output logic        done0,
    output logic        done1,
    output logic [31:0] res,
    output logic        res_zero,
    output logic        err,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic        last_grant;
    logic        winner;
    logic        pick;
    logic [31:0] lat_a;
    logic [31:0] lat_b;
    logic [5:0]  lat_func;
    logic [1:0]  lat_op;
    logic        done0_q;
    logic        done1_q;
    logic        err_q;
    logic        busy_q;
    logic        exec_active;

    // Choose the requester to grant.
    // A lone requester always wins.
    // On a tie, the one not granted last time wins.
    always_comb begin
        pick = 1'b0;
        if (req0 && req1) begin
            pick = ~last_grant;
        end else if (req1) begin
            pick = 1'b1;
        end
    end

    // Control FSM.
    // It latches the winner's operands, captures the ALU result, and produces the registered status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            winner     <= 1'b0;
            lat_a      <= '0;
            lat_b      <= '0;
            lat_func   <= '0;
            lat_op     <= '0;
            res        <= '0;
            res_zero   <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done0_q <= 1'b0;
                    done1_q <= 1'b0;
                    err_q   <= 1'b0;
                    if (req0 || req1) begin
                        winner     <= pick;
                        last_grant <= pick;
                        lat_a      <= pick ? a1 : a0;
                        lat_b      <= pick ? b1 : b0;
                        lat_func   <= pick ? func1 : func0;
                        lat_op     <= pick ? op1 : op0;
                        busy_q     <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (lat_op == 2'b11) begin
                        res      <= '0;
                        res_zero <= 1'b1;
                        err_q    <= 1'b1;
                    end else begin
                        res      <= alu_out;
                        res_zero <= alu_zero;
                        err_q    <= 1'b0;
                    end
                    done0_q <= ~winner;
                    done1_q <= winner;
                    state   <= DONE;
                end
                DONE: begin
                    done0_q <= 1'b0;
                    done1_q <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    done0_q <= 1'b0;
                    done1_q <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // The ALU sees the latched request only during EXEC.
    // Status outputs are forced low while reset is held, so nothing leaks out of an aborted operation.
    assign exec_active = (state == EXEC) && !rst;
    assign alu_A       = exec_active ? lat_a    : '0;
    assign alu_B       = exec_active ? lat_b    : '0;
    assign alu_func    = exec_active ? lat_func : '0;
    assign alu_op      = exec_active ? lat_op   : '0;
    assign done0       = done0_q & ~rst;
    assign done1       = done1_q & ~rst;
    assign err         = err_q   & ~rst;
    assign busy        = busy_q  & ~rst;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter.
// It models the shared ALU as the environment.
// Stimulus tasks push hand-computed expected completions.
// A negedge monitor pops and compares an expected completion on every done pulse.
module tb_alu_arbiter;

    logic        clk;
    logic        rst;
    logic        req0, req1;
    logic [31:0] a0, b0, a1, b1;
    logic [5:0]  func0, func1;
    logic [1:0]  op0, op1;
    logic [31:0] alu_A, alu_B;
    logic [5:0]  alu_func;
    logic [1:0]  alu_op;
    logic [31:0] alu_out;
    logic        alu_zero;
    logic        done0, done1;
    logic [31:0] res;
    logic        res_zero;
    logic        err;
    logic        busy;

    typedef struct {
        bit          who;
        logic [31:0] res;
        bit          zero;
        bit          err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    alu_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .req1     (req1),
        .a0       (a0),
        .b0       (b0),
        .a1       (a1),
        .b1       (b1),
        .func0    (func0),
        .func1    (func1),
        .op0      (op0),
        .op1      (op1),
        .alu_A    (alu_A),
        .alu_B    (alu_B),
        .alu_func (alu_func),
        .alu_op   (alu_op),
        .alu_out  (alu_out),
        .alu_zero (alu_zero),
        .done0    (done0),
        .done1    (done1),
        .res      (res),
        .res_zero (res_zero),
        .err      (err),
        .busy     (busy)
    );

    // Free-running clock with a 10-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU environment.
    // ALUop 11 yields a non-zero pattern, so an un-suppressed ALU result would be visible.
    always_comb begin
        alu_out = '0;
        case (alu_op)
            2'b00: alu_out = alu_A + alu_B;
            2'b01: alu_out = alu_A - alu_B;
            2'b10: begin
                case (alu_func)
                    6'h20: alu_out = alu_A + alu_B;
                    6'h22: alu_out = alu_A - alu_B;
                    6'h24: alu_out = alu_A & alu_B;
                    6'h25: alu_out = alu_A | alu_B;
                    6'h2a: alu_out = {31'b0, $signed(alu_A) < $signed(alu_B)};
                    default: alu_out = '0;
                endcase
            end
            default: alu_out = 32'hDEADBEEF;
        endcase
    end
    assign alu_zero = (alu_out == 32'h0);

    // Compare one value and count it.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (!rst && (done0 || done1)) begin
            checkOutput("done_exclusive", {31'b0, done0 & done1}, 32'h0);
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", {31'b0, done1}, 32'hFFFFFFFF);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("done_who", {31'b0, done1}, {31'b0, mon_e.who});
                checkOutput("res", res, mon_e.res);
                checkOutput("res_zero", {31'b0, res_zero}, {31'b0, mon_e.zero});
                checkOutput("err", {31'b0, err}, {31'b0, mon_e.err});
            end
        end
    end

    // Hold reset for two edges, then release it.
    task automatic doReset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Issue one request and wait (bounded) for its done pulse.
    // When drop is set, the request is withdrawn and the operands are corrupted after the grant.
    task automatic applyStimulus(input bit who, input logic [31:0] a, input logic [31:0] b,
                                 input logic [5:0] f, input logic [1:0] op,
                                 input logic [31:0] er, input bit ez, input bit ee, input bit drop);
        bit seen;
        @(posedge clk); #1;
        if (!who) begin
            req0 = 1'b1; a0 = a; b0 = b; func0 = f; op0 = op;
        end else begin
            req1 = 1'b1; a1 = a; b1 = b; func1 = f; op1 = op;
        end
        sb.push_back('{who, er, ez, ee});
        seen = 1'b0;
        for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
            @(negedge clk);
            if (who ? done1 : done0) begin
                seen = 1'b1;
                checkOutput("latency", cyc, 32'd2);
            end else if (cyc == 1 && drop) begin
                req0 = 1'b0; req1 = 1'b0;
                a0 = 32'h1234; b0 = 32'h5678; a1 = 32'h1234; b1 = 32'h5678;
                op0 = 2'b00; op1 = 2'b00; func0 = '0; func1 = '0;
            end
        end
        if (!seen) checkOutput("done_timeout", 32'h0, 32'h1);
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    // Watchdog so the bench always terminates.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        bit seen;
        rst = 1'b1;
        req0 = 0; req1 = 0;
        a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        func0 = 0; func1 = 0; op0 = 0; op1 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_done0", {31'b0, done0}, 32'h0);
        checkOutput("rst_done1", {31'b0, done1}, 32'h0);
        checkOutput("rst_err", {31'b0, err}, 32'h0);
        checkOutput("rst_busy", {31'b0, busy}, 32'h0);
        checkOutput("rst_alu_A", alu_A, 32'h0);
        checkOutput("rst_alu_op", {30'b0, alu_op}, 32'h0);
        checkOutput("rst_res", res, 32'h0);
        checkOutput("rst_res_zero", {31'b0, res_zero}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        applyStimulus(1'b0, 32'd5, 32'd3, 6'h00, 2'b00, 32'd8, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'd7, 32'd7, 6'h00, 2'b01, 32'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'hF0, 32'h0F, 6'h25, 2'b10, 32'hFF, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'd9, 32'd4, 6'h00, 2'b11, 32'd0, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'd10, 32'd20, 6'h00, 2'b00, 32'd30, 1'b0, 1'b0, 1'b1);

        // Contention after reset: requester 0 wins first, then they alternate.
        doReset();
        @(posedge clk); #1;
        req0 = 1'b1; a0 = 32'd1; b0 = 32'd1; op0 = 2'b00; func0 = '0;
        req1 = 1'b1; a1 = 32'd2; b1 = 32'd2; op1 = 2'b00; func1 = '0;
        sb.push_back('{1'b0, 32'd2, 1'b0, 1'b0});
        sb.push_back('{1'b1, 32'd4, 1'b0, 1'b0});
        sb.push_back('{1'b0, 32'd2, 1'b0, 1'b0});
        for (int cyc = 0; cyc < 9; cyc++) begin
            @(negedge clk);
            checkOutput("cont_done0", {31'b0, done0}, {31'b0, (cyc == 2 || cyc == 8)});
            checkOutput("cont_done1", {31'b0, done1}, {31'b0, (cyc == 5)});
        end
        req0 = 1'b0; req1 = 1'b0;

        // Reset in flight: the grant is dropped, and a held request is granted fresh.
        doReset();
        @(posedge clk); #1;
        req0 = 1'b1; a0 = 32'd5; b0 = 32'd3; op0 = 2'b00; func0 = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("inrst_busy", {31'b0, busy}, 32'h0);
        checkOutput("inrst_alu_A", alu_A, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        sb.push_back('{1'b0, 32'd8, 1'b0, 1'b0});
        @(negedge clk);
        checkOutput("abort_done0", {31'b0, done0}, 32'h0);
        checkOutput("abort_busy", {31'b0, busy}, 32'h0);
        checkOutput("abort_res", res, 32'h0);
        seen = 1'b0;
        for (int cyc = 0; cyc < 8 && !seen; cyc++) begin
            @(negedge clk);
            if (done0) begin
                seen = 1'b1;
                checkOutput("regrant_latency", cyc, 32'd1);
            end
        end
        if (!seen) checkOutput("regrant_timeout", 32'h0, 32'h1);
        req0 = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("sb_empty", sb.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have ports, one per line as listed: name, direction, width, meaning.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0 / req1  input  1 each  request from requester 0 / 1.
REQ-005 a0, b0 / a1, b1  input  32 each  operands of requester 0 / 1.
REQ-006 func0 / func1  input  6 each  function field of requester 0 / 1.
REQ-007 op0 / op1  input  2 each  ALUop of requester 0 / 1.
REQ-008 alu_A, alu_B  output  32 each  operands driven to the shared combinational ALU.
REQ-009 alu_func  output  6  function field to the ALU.
REQ-010 alu_op  output  2  ALUop to the ALU.
REQ-011 alu_out  input  32  ALU result.
REQ-012 alu_zero  input  1  ALU zero flag.
REQ-013 done0 / done1  output  1 each  one-cycle completion pulse to requester 0 / 1.
REQ-014 res  output  32  registered result of the last completed operation.
REQ-015 res_zero  output  1  registered zero flag of the last completed operation.
REQ-016 err  output  1  one-cycle pulse, asserted with done, when the completed op used ALUop 2'b11.
REQ-017 busy  output  1  high in EXEC and DONE.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, EXEC and DONE.
REQ-019 In IDLE with no request pending, the FSM SHALL stay in IDLE.
REQ-020 In IDLE with req0 or req1 high, the block SHALL latch the winner's a, b, func and op into internal registers, record the winner, and enter EXEC.
REQ-021 Arbitration SHALL be round-robin via a last-grant bit: a single requester always wins; on simultaneous requests, the requester not granted last wins.
REQ-022 The last-grant bit SHALL update only on a grant in IDLE, and SHALL reset to 1, so requester 0 wins the first simultaneous contest.
REQ-023 In EXEC, alu_A, alu_B, alu_func and alu_op SHALL be driven from the latched registers.
REQ-024 At the end of the EXEC cycle, the block SHALL capture alu_out into res and alu_zero into res_zero, and enter DONE.
REQ-025 Exception: if the latched op is 2'b11, the block SHALL capture res=0 and res_zero=1 instead of the ALU outputs, and SHALL raise err in DONE.
REQ-026 In DONE, the block SHALL assert done0 or done1 (the winner's only) for exactly one cycle, then return to IDLE unconditionally.
REQ-027 In IDLE and DONE, alu_A, alu_B, alu_func and alu_op SHALL be driven to 0.
REQ-028 res and res_zero SHALL hold their values until the next capture.
REQ-029 Latency SHALL be as follows: a request sampled in IDLE in cycle n produces done in cycle n+2, and the next grant can occur no earlier than cycle n+3.
REQ-030 Throughput SHALL be at most one operation per 3 cycles.
REQ-031 Requesters SHALL hold req and operands until their done pulse; a req still high in the cycle after done SHALL be treated as a new request.
REQ-032 Requests arriving while busy SHALL NOT be lost; they are simply sampled at the next IDLE.
REQ-033 If a granted requester drops req during EXEC or DONE, the operation SHALL complete and the done pulse SHALL still be issued.
REQ-034 Operand changes after the grant SHALL NOT affect the result.
REQ-035 done0 and done1 SHALL never be high in the same cycle.
REQ-036 Arithmetic SHALL be fully delegated to the ALU; the block SHALL perform no width extension or arithmetic of its own.

Reset
REQ-037 With rst high at a clock edge, the block SHALL enter IDLE and clear last-grant to 1, res to 0, res_zero to 0 and the latched registers to 0.
REQ-038 While in reset, done0, done1, err, busy and all alu_* outputs SHALL read 0.
REQ-039 rst asserted during EXEC or DONE SHALL abort the operation: no done pulse is issued, and the in-flight request is dropped.
REQ-040 rst SHALL take priority over every transition.

Verification
REQ-041 Single add: req0=1, a0=5, b0=3, op0=00 in cycle 0 -> done0=1, res=8, res_zero=0 in cycle 2; done1 stays 0.
REQ-042 Subtract to zero: req1=1, a1=7, b1=7, op1=01 -> done1 in cycle 2, res=0, res_zero=1.
REQ-043 Contention: after reset, req0 and req1 held high together (a0=1, b0=1, a1=2, b1=2, op=00) -> done0 with res=2 in cycle 2, done1 with res=4 in cycle 5, done0 again in cycle 8.
REQ-044 Funct path: req0, op0=10, func0=6'h25, a0=32'hF0, b0=32'h0F -> res=32'hFF, done0 in cycle 2.
REQ-045 Illegal op: req1, op1=11 -> done1 and err in cycle 2, res=0, res_zero=1.
REQ-046 Reset in flight: req0 granted in cycle 0, rst=1 in cycle 1 -> no done0, busy=0, res=0 in cycle 2; a held req0 is granted fresh once rst is low.
